// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv UART transmitter.
//   uart_state_e        : transmitter FSM states
//   UART_RESET_DIVISOR  : baud divisor after reset (100 MHz / 115200)
//   UART_PARITY_*_BIT   : bit positions inside the 2-bit parity-mode register
//   uart_parity_bit()   : parity bit for a data byte under a given mode
package riscv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned UART_RESET_DIVISOR = 868;

    // Parity-mode encoding: bit 0 enables parity, bit 1 selects odd (1) / even (0).
    localparam int unsigned UART_PARITY_EN_BIT  = 0;
    localparam int unsigned UART_PARITY_ODD_BIT = 1;

    function automatic logic uart_parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ mode[UART_PARITY_ODD_BIT];
    endfunction

    function automatic logic uart_parity_enabled(input logic [1:0] mode);
        return mode[UART_PARITY_EN_BIT];
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO, WIDTH x DEPTH, first-word fall-through read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   clk_i, rst_i     : clock, synchronous active-high reset (clears pointers)
//   push_i, wdata_i  : write request and data; ignored when full unless pop_i is also set
//   pop_i            : read request; ignored when empty
//   rdata_o          : head entry
//   full_o, empty_o  : occupancy flags
module riscv_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// Memory-mapped UART transmitter driven by the execute-stage store path.
// Bytes are queued in a FIFO and sent LSB-first as 8-bit frames with an
// optional parity bit; each bit lasts exactly `divisor` core cycles.
// Build option: define RISCV_UART_TX_PARITY_EN to include the parity register
// and PARITY state; without it every frame is 8N1 and parity writes are ignored.
//   i_riscv_uart_tx_clk / _rst            : core clock, synchronous active-high reset
//   i_riscv_uart_tx_globstall             : blocks every write strobe
//   i_riscv_uart_tx_valid                 : push wdata[7:0] into the TX FIFO
//   i_riscv_uart_tx_baud_divisor_wren     : divisor <- wdata[DIV_WIDTH-1:0] (0 stored as 1)
//   i_riscv_uart_tx_parity_wren           : parity mode <- wdata[1:0]
//   i_riscv_uart_tx_wdata                 : forwarded store data
//   o_riscv_uart_tx_serial                : registered TX line, idle high
//   o_riscv_uart_tx_busy                  : FSM active or FIFO non-empty
//   o_riscv_uart_tx_fifo_full / _empty    : FIFO occupancy flags
module riscv_uart_tx
    import riscv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned RESET_DIVISOR = UART_RESET_DIVISOR
) (
    input  logic        i_riscv_uart_tx_clk,
    input  logic        i_riscv_uart_tx_rst,
    input  logic        i_riscv_uart_tx_globstall,
    input  logic        i_riscv_uart_tx_valid,
    input  logic        i_riscv_uart_tx_baud_divisor_wren,
    input  logic        i_riscv_uart_tx_parity_wren,
    input  logic [63:0] i_riscv_uart_tx_wdata,
    output logic        o_riscv_uart_tx_serial,
    output logic        o_riscv_uart_tx_busy,
    output logic        o_riscv_uart_tx_fifo_full,
    output logic        o_riscv_uart_tx_fifo_empty
);

    localparam logic [DIV_WIDTH-1:0] DivReset = DIV_WIDTH'(RESET_DIVISOR);
    localparam logic [DIV_WIDTH-1:0] DivOne   = DIV_WIDTH'(1);

    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       frame_load;

    uart_state_e          state_q;
    logic                 serial_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_snap_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic [DIV_WIDTH-1:0] div_q, div_d;

    logic unused_wdata;
    assign unused_wdata = ^i_riscv_uart_tx_wdata[63:DIV_WIDTH];

    assign fifo_push = i_riscv_uart_tx_valid && !i_riscv_uart_tx_globstall;

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_riscv_uart_tx_clk),
        .rst_i   (i_riscv_uart_tx_rst),
        .push_i  (fifo_push),
        .wdata_i (i_riscv_uart_tx_wdata[7:0]),
        .pop_i   (frame_load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Baud divisor register; a zero divisor would stall the bit counter, so clamp to 1.
    always_comb begin
        div_d = div_q;
        if (i_riscv_uart_tx_baud_divisor_wren && !i_riscv_uart_tx_globstall) begin
            div_d = (i_riscv_uart_tx_wdata[DIV_WIDTH-1:0] == '0) ? DivOne
                                                                 : i_riscv_uart_tx_wdata[DIV_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_riscv_uart_tx_clk) begin
        if (i_riscv_uart_tx_rst) div_q <= DivReset;
        else                     div_q <= div_d;
    end

`ifdef RISCV_UART_TX_PARITY_EN
    logic [1:0] par_mode_q, par_mode_d;
    logic       par_en_q;
    logic       par_bit_q;

    always_comb begin
        par_mode_d = par_mode_q;
        if (i_riscv_uart_tx_parity_wren && !i_riscv_uart_tx_globstall) begin
            par_mode_d = i_riscv_uart_tx_wdata[1:0];
        end
    end

    always_ff @(posedge i_riscv_uart_tx_clk) begin
        if (i_riscv_uart_tx_rst) par_mode_q <= 2'b00;
        else                     par_mode_q <= par_mode_d;
    end

    // Parity setting is frozen per frame together with the divisor.
    always_ff @(posedge i_riscv_uart_tx_clk) begin
        if (i_riscv_uart_tx_rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (frame_load) begin
            par_en_q  <= uart_parity_enabled(par_mode_q);
            par_bit_q <= uart_parity_bit(fifo_rdata, par_mode_q);
        end
    end
`else
    logic unused_parity;
    assign unused_parity = i_riscv_uart_tx_parity_wren;
`endif

    // A new frame starts from IDLE, or straight from the last STOP cycle to avoid an idle gap.
    assign frame_load = !fifo_empty &&
                        ((state_q == StIdle) || ((state_q == StStop) && (cnt_q == '0)));

    always_ff @(posedge i_riscv_uart_tx_clk) begin
        if (i_riscv_uart_tx_rst) begin
            state_q    <= StIdle;
            serial_q   <= 1'b1;
            cnt_q      <= '0;
            div_snap_q <= DivReset;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else if (frame_load) begin
            state_q    <= StStart;
            serial_q   <= 1'b0;
            cnt_q      <= div_q - DivOne;
            div_snap_q <= div_q;
            bit_idx_q  <= '0;
            shift_q    <= fifo_rdata;
        end else begin
            unique case (state_q)
                StIdle: begin
                    serial_q <= 1'b1;
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        state_q  <= StData;
                        serial_q <= shift_q[0];
                        cnt_q    <= div_snap_q - DivOne;
                    end else begin
                        cnt_q <= cnt_q - DivOne;
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        cnt_q <= div_snap_q - DivOne;
                        if (bit_idx_q == 3'd7) begin
`ifdef RISCV_UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q  <= StParity;
                                serial_q <= par_bit_q;
                            end else begin
                                state_q  <= StStop;
                                serial_q <= 1'b1;
                            end
`else
                            state_q  <= StStop;
                            serial_q <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            serial_q  <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - DivOne;
                    end
                end
`ifdef RISCV_UART_TX_PARITY_EN
                StParity: begin
                    if (cnt_q == '0) begin
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                        cnt_q    <= div_snap_q - DivOne;
                    end else begin
                        cnt_q <= cnt_q - DivOne;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - DivOne;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    serial_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_riscv_uart_tx_serial     = serial_q;
    assign o_riscv_uart_tx_busy       = (state_q != StIdle) || !fifo_empty;
    assign o_riscv_uart_tx_fifo_full  = fifo_full;
    assign o_riscv_uart_tx_fifo_empty = fifo_empty;

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Scoreboard bench for riscv_uart_tx: each push records the expected frame in a
// queue; an independent monitor watches the serial line and checks every bit.
module tb_riscv_uart_tx;

    logic        clk;
    logic        rst;
    logic        globstall;
    logic        valid;
    logic        div_wren;
    logic        par_wren;
    logic [63:0] wdata;
    logic        serial;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;

    int cyc    = 0;
    int n_vec  = 0;
    int n_fail = 0;
    bit mon_en   = 1'b1;
    bit in_frame = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pe;
        bit         pb;
        int         sc;   // expected first start-bit sample cycle, -1 = don't care
        bit         b2b;  // must follow the previous frame with no idle gap
    } exp_t;

    exp_t exp_q[$];

    riscv_uart_tx dut (
        .i_riscv_uart_tx_clk               (clk),
        .i_riscv_uart_tx_rst               (rst),
        .i_riscv_uart_tx_globstall         (globstall),
        .i_riscv_uart_tx_valid             (valid),
        .i_riscv_uart_tx_baud_divisor_wren (div_wren),
        .i_riscv_uart_tx_parity_wren       (par_wren),
        .i_riscv_uart_tx_wdata             (wdata),
        .o_riscv_uart_tx_serial            (serial),
        .o_riscv_uart_tx_busy              (busy),
        .o_riscv_uart_tx_fifo_full         (fifo_full),
        .o_riscv_uart_tx_fifo_empty        (fifo_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div, input bit pe, input bit pb,
                                input int sc, input bit b2b);
        exp_t e;
        e.data = d; e.div = div; e.pe = pe; e.pb = pb; e.sc = sc; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
        @(negedge clk);
    endtask

    task automatic write_div(input logic [63:0] v);
        div_wren = 1'b1;
        wdata    = v;
        @(negedge clk);
        div_wren = 1'b0;
        wdata    = '0;
    endtask

    task automatic write_par(input logic [63:0] v);
        par_wren = 1'b1;
        wdata    = v;
        @(negedge clk);
        par_wren = 1'b0;
        wdata    = '0;
    endtask

    // Monitor: one comparison per bit slot, using every sample within the slot.
    initial begin : monitor
        exp_t       e;
        logic [10:0] bits;
        int         nb;
        int         prev_end;
        int         fr;
        logic       act;
        prev_end = -1;
        fr       = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && serial === 1'b0) begin
                in_frame = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_start: line low at cycle %0d, required idle high",
                             cyc);
                    for (int k = 0; k < 20000 && serial === 1'b0; k++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    if (e.sc >= 0) check("start_cycle", cyc, e.sc);
                    if (e.b2b)     check("frame_gap", cyc, prev_end);
                    bits      = '1;
                    bits[0]   = 1'b0;
                    bits[8:1] = e.data;
                    nb        = 10;
                    if (e.pe) begin
                        bits[9] = e.pb;
                        nb      = 11;
                    end
                    for (int j = 0; j < nb; j++) begin
                        act = serial;
                        for (int k = 0; k < e.div; k++) begin
                            if (j != 0 || k != 0) @(negedge clk);
                            if (k == 0 || serial !== bits[j]) act = serial;
                        end
                        check($sformatf("frame%0d_bit%0d", fr, j), act, bits[j]);
                    end
                    prev_end = cyc + 1;
                    fr++;
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : stim
        int p;
        rst = 1'b1; globstall = 1'b0; valid = 1'b0;
        div_wren = 1'b0; par_wren = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_serial", serial, 1);
        check("reset_busy", busy, 0);
        check("reset_full", fifo_full, 0);
        check("reset_empty", fifo_empty, 1);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 at divisor 4: start one cycle after the push, busy low 40 cycles later.
        write_div(4);
        p = cyc;
        valid = 1'b1; wdata = 64'hA5;
        expect_frame(8'hA5, 4, 0, 0, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        check("push_not_empty", fifo_empty, 0);
        @(negedge clk);
        check("pop_empty", fifo_empty, 1);
        check("pop_busy", busy, 1);
        wait_until(p + 41);
        check("busy_last_stop", busy, 1);
        wait_until(p + 42);
        check("busy_fall", busy, 0);
        wait_idle(200);

`ifdef RISCV_UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0; 44-cycle frames.
        write_par(2'b01);
        p = cyc;
        valid = 1'b1; wdata = 64'h07;
        expect_frame(8'h07, 4, 1, 1, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_until(p + 45);
        check("par_busy_last", busy, 1);
        wait_until(p + 46);
        check("par_busy_fall", busy, 0);
        wait_idle(200);
        write_par(2'b11);
        p = cyc;
        valid = 1'b1; wdata = 64'h07;
        expect_frame(8'h07, 4, 1, 0, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_idle(200);
        write_par(2'b00);
`endif

        // Globally stalled strobes must change nothing (FIFO, divisor, parity).
        globstall = 1'b1; valid = 1'b1; div_wren = 1'b1; par_wren = 1'b1; wdata = 64'h33;
        @(negedge clk);
        globstall = 1'b0; valid = 1'b0; div_wren = 1'b0; par_wren = 1'b0; wdata = '0;
        check("stall_empty", fifo_empty, 1);
        check("stall_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("stall_serial", serial, 1);

        // Ten consecutive pushes: one pop during the burst, so only the tenth is dropped.
        p = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check("burst_full", fifo_full, 1);
            valid = 1'b1;
            wdata = 64'(i + 1);
            if (i < 9) expect_frame(8'(i + 1), 4, 0, 0, (i == 0) ? p + 2 : -1, i != 0);
            @(negedge clk);
        end
        valid = 1'b0; wdata = '0;
        check("drop_full", fifo_full, 1);
        check("drop_not_empty", fifo_empty, 0);
        // Push exactly when the first frame's STOP pops: accepted while full.
        wait_until(p + 41);
        valid = 1'b1; wdata = 64'h0B;
        expect_frame(8'h0B, 4, 0, 0, -1, 1);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        check("push_pop_full", fifo_full, 1);
        wait_idle(1000);

        // Divisor change mid-frame only affects the following frame.
        p = cyc;
        valid = 1'b1; wdata = 64'h3C;
        expect_frame(8'h3C, 4, 0, 0, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_until(p + 10);
        write_div(2);
        valid = 1'b1; wdata = 64'hC3;
        expect_frame(8'hC3, 2, 0, 0, -1, 1);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_idle(200);

        // Divisor 0 behaves as 1.
        write_div(0);
        p = cyc;
        valid = 1'b1; wdata = 64'h5A;
        expect_frame(8'h5A, 1, 0, 0, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_idle(200);

        // Reset during DATA with a second byte queued.
        mon_en = 1'b0;
        write_div(4);
        p = cyc;
        valid = 1'b1; wdata = 64'h00;
        @(negedge clk);
        wdata = 64'h81;
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_until(p + 8);
        check("pre_rst_serial", serial, 0);
        check("pre_rst_empty", fifo_empty, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_serial", serial, 1);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_full", fifo_full, 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        // Divisor back at its reset value of 868 cycles per bit.
        p = cyc;
        valid = 1'b1; wdata = 64'h96;
        expect_frame(8'h96, 868, 0, 0, p + 2, 0);
        @(negedge clk);
        valid = 1'b0; wdata = '0;
        wait_idle(9000);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_uart_tx.md
# riscv_uart_tx

Memory-mapped UART transmitter fed by the load/store unit of the execute stage. It consumes the execute stage's `uart_tx_valid`, `baud_divisor_wren` and `parity_wren` strobes together with the forwarded store data. Bytes are buffered in a small FIFO and serialised LSB-first as 8-bit frames, with an optional parity bit. Software polls the full/busy flags to pace its writes.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DIV_WIDTH`, 16: baud divisor width.
- `RESET_DIVISOR`, 868: divisor after reset (100 MHz / 115200).
- `i_riscv_uart_tx_clk` in 1: core clock.
- `i_riscv_uart_tx_rst` in 1: reset, synchronous, active-high.
- `i_riscv_uart_tx_globstall` in 1: when high, all write strobes are ignored.
- `i_riscv_uart_tx_valid` in 1: push `i_riscv_uart_tx_wdata[7:0]` into the FIFO.
- `i_riscv_uart_tx_baud_divisor_wren` in 1: divisor ← `wdata[DIV_WIDTH-1:0]`.
- `i_riscv_uart_tx_parity_wren` in 1: parity mode ← `wdata[1:0]`. Bit 0 is enable; bit 1 selects odd (1) or even (0).
- `i_riscv_uart_tx_wdata` in 64: store data from execute.
- `o_riscv_uart_tx_serial` out 1: TX line, registered, idle high.
- `o_riscv_uart_tx_busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `o_riscv_uart_tx_fifo_full` out 1: FIFO full.
- `o_riscv_uart_tx_fifo_empty` out 1: FIFO empty.

## Operation
- **Reset values:**
  - serial = 1, busy = 0, fifo_full = 0, fifo_empty = 1.
  - divisor = `RESET_DIVISOR`; parity mode = 00.
  - FSM = IDLE; FIFO pointers cleared.
- **Reset mid-frame:** the line returns high the next cycle. The frame is abandoned and the FIFO is discarded.
- **Config writes:**
  - Take effect at the next clock edge.
  - A written divisor of 0 is stored as 1.
  - The FSM snapshots divisor and parity mode on IDLE→START, so a frame already on the line is unaffected.
- **Push while full:** the byte is dropped and no state changes. Push and pop in the same cycle while full: both happen, count unchanged, byte accepted.
- **Strobe priority:** if several strobes are active in one cycle, each acts independently on its own register.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, load the bit counter, go to START.
  - START: line 0 for one bit time, then DATA.
  - DATA: 8 bits, LSB first, one bit time each; a 3-bit index counts them. After bit 7, go to PARITY if parity is enabled, else STOP.
  - PARITY: even parity is the XOR of the 8 data bits; odd parity is its inverse.
  - STOP: line 1 for one bit time. If the FIFO is then non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- **Bit time:** a down-counter loaded with divisor−1 on entry to each bit. The state advances when it reaches 0, so every bit lasts exactly `divisor` cycles.

## Timing
- A push sampled at edge N is stored by edge N. The FSM pops at edge N+1, and serial = 0 from edge N+1 on. The start bit therefore appears one cycle after the push is sampled.
- Frame length: 10×divisor cycles, or 11×divisor with parity.
- Back-to-back frames have zero gap.
- The full/empty flags reflect pushes and pops from the edge on which they occur.
- busy falls on the cycle the FSM returns to IDLE with an empty FIFO.

## Configuration
- Macro `RISCV_UART_TX_PARITY_EN`.
- Defined: the parity register and the PARITY state exist as described.
- Undefined: `parity_wren` is ignored, the PARITY state is not generated, and all frames are 8N1 (10×divisor cycles).

## Structure
- Shared package `riscv_pkg` holds:
  - the UART state enum (IDLE/START/DATA/PARITY/STOP);
  - the `UART_RESET_DIVISOR` constant;
  - the parity-mode encoding constants.
- Sub-module `riscv_sync_fifo`: a parameterised width×depth synchronous FIFO with push/pop/full/empty and pointers carrying an extra wrap bit. `riscv_uart_tx` instantiates it with 8-bit width.
- The FSM, baud counter and shift register live in the top module.

## Test plan
- Reset, divisor = 4, push 0xA5:
  - start bit appears one cycle after the push;
  - the line carries 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles;
  - busy falls 40 cycles after the start bit begins.
- Parity enabled:
  - even parity, byte 0x07 → parity bit 1;
  - odd parity, byte 0x07 → parity bit 0;
  - frame is 44 cycles at divisor 4.
- Push 9 bytes in consecutive cycles with `FIFO_DEPTH` = 8:
  - fifo_full asserts;
  - the 9th byte is dropped only if no pop occurred in that cycle;
  - frames are back-to-back with no idle gap.
- Change the divisor from 4 to 2 mid-frame: the current frame stays at 4 cycles/bit and the next frame runs at 2 cycles/bit. Write a divisor of 0: frames run at 1 cycle/bit.
- Push with globstall = 1: the FIFO is unchanged.
- Assert reset during DATA: serial = 1 the next cycle, fifo_empty = 1, divisor = 868.
